// File: rtl/pc_fetch_pkg.sv
// pc_fetch shared types and constants.
// FSM encoding, reset/window defaults and the fetch window check.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2,
    FS_ERR  = 2'd3
  } fs_e;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_BASE = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_SIZE = 32'h0000_1000;

  // Upper bound is formed in 33 bits so a window ending at 4 GiB cannot wrap.
  function automatic logic in_window(
    input logic [29:0] wa,
    input logic [31:0] base,
    input logic [31:0] size
  );
    logic [32:0] ba;
    logic [32:0] lim;
    ba  = {1'b0, wa, 2'b00};
    lim = {1'b0, base} + {1'b0, size};
    return (ba >= {1'b0, base}) && (ba < lim);
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory req/ack bus between pc_fetch and imem.
// master drives the request, slave returns the word.
interface pc_fetch_if;

  logic        req;
  logic [29:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );

endinterface

// File: rtl/pc_fetch.sv
// PC register and instruction-fetch sequencer.
// Commits NPC, fetches the word at PC over req/ack and latches it into IR.
import pc_fetch_pkg::*;

module pc_fetch #(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] IMEM_BASE = DEF_IMEM_BASE,
  parameter logic [31:0] IMEM_SIZE = DEF_IMEM_SIZE,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] npc,
  input  logic        pc_wr,
  input  logic        fetch_start,
  pc_fetch_if.master  imem,
  output logic [29:0] pc,
  output logic [31:0] instr,
  output logic [25:0] imminstr,
  output logic        turn,
  output logic        fetch_done,
  output logic        busy,
  output logic        fetch_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  fs_e         state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        req_q, req_d;
  logic [29:0] addr_q, addr_d;
  logic        turn_q, turn_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [29:0] pend_q, pend_d;
  logic        pend_v_q, pend_v_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FS_IDLE;
      pc_q     <= RESET_PC[31:2];
      instr_q  <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      turn_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      turn_q   <= turn_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    req_d    = req_q;
    addr_d   = addr_q;
    turn_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    unique case (state_q)
      FS_IDLE: begin
        // Deferred write lands first; a fresh pc_wr overrides it.
        if (pend_v_q) begin
          pc_d     = pend_q;
          pend_v_d = 1'b0;
        end
        if (pc_wr) pc_d = npc;
        if (fetch_start && !done_q) begin
          if (in_window(pc_d, IMEM_BASE, IMEM_SIZE)) begin
            addr_d  = pc_d;
            state_d = FS_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = FS_ERR;
          end
        end
      end
      FS_REQ: begin
        req_d   = 1'b1;
        cnt_d   = '0;
        state_d = FS_WAIT;
      end
      FS_WAIT: begin
        if (imem.ack) begin
          instr_d = imem.rdata;
          req_d   = 1'b0;
          turn_d  = 1'b1;
          done_d  = 1'b1;
          state_d = FS_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = FS_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FS_ERR: ;
      default: ;
    endcase
    if (pc_wr && (state_q == FS_REQ || state_q == FS_WAIT)) begin
      pend_d   = npc;
      pend_v_d = 1'b1;
    end
  end

  assign imem.req   = req_q;
  assign imem.addr  = addr_q;
  assign pc         = pc_q;
  assign instr      = instr_q;
  assign imminstr   = instr_q[25:0];
  assign turn       = turn_q;
  assign fetch_done = done_q;
  assign busy       = (state_q == FS_REQ) || (state_q == FS_WAIT);
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch.
// Directed scenarios plus randomized fetches against a transaction model.
module tb_pc_fetch;

  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam logic [31:0] SIZE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] npc;
  logic        pc_wr;
  logic        fetch_start;
  logic [29:0] pc;
  logic [31:0] instr;
  logic [25:0] imminstr;
  logic        turn;
  logic        fetch_done;
  logic        busy;
  logic        fetch_err;

  pc_fetch_if imem ();

  pc_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .npc         (npc),
    .pc_wr       (pc_wr),
    .fetch_start (fetch_start),
    .imem        (imem),
    .pc          (pc),
    .instr       (instr),
    .imminstr    (imminstr),
    .turn        (turn),
    .fetch_done  (fetch_done),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  int          n_run = 0;
  int          n_fail = 0;
  int          ack_delay = 0;
  logic [31:0] mem_data = '0;
  logic        ack_force = 1'b0;
  logic [31:0] force_data = '0;
  logic        ack_r = 1'b0;
  int          wcnt = 0;

  assign imem.ack   = ack_r | ack_force;
  assign imem.rdata = ack_force ? force_data : mem_data;

  // Memory answers after ack_delay idle WAIT cycles; -1 means never.
  initial forever begin
    @(posedge clk);
    #2;
    if (rst !== 1'b1 || imem.req !== 1'b1) begin
      wcnt  = 0;
      ack_r = 1'b0;
    end else begin
      ack_r = (ack_delay >= 0) && (wcnt == ack_delay);
      wcnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic bit model_inwin(input logic [29:0] w);
    longint b;
    b = longint'({w, 2'b00});
    return (b >= longint'(BASE)) && (b < longint'(BASE) + longint'(SIZE));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pc_wr = 1'b0;
    fetch_start = 1'b0;
    npc = '0;
    ack_force = 1'b0;
    ack_delay = 0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic go(input logic wr, input logic [29:0] nv, output int edges);
    pc_wr = wr;
    npc = nv;
    fetch_start = 1'b1;
    step();
    pc_wr = 1'b0;
    fetch_start = 1'b0;
    edges = 1;
    while (!fetch_done && !fetch_err && edges < 40) begin
      step();
      edges++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_run++;
    if (pc !== 30'h0C00) begin
      n_fail++;
      $display("FAIL reset_pc got %h want %h", pc, 30'h0C00);
    end
    n_run++;
    if (instr !== 32'h0 || imem.addr !== 30'h0) begin
      n_fail++;
      $display("FAIL reset_regs instr %h addr %h want 0", instr, imem.addr);
    end
    n_run++;
    if ({imem.req, busy, turn, fetch_done, fetch_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 00000",
               {imem.req, busy, turn, fetch_done, fetch_err});
    end
  endtask

  task automatic test_basic_fetch();
    mem_data = 32'h2408_0005;
    ack_delay = 0;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    n_run++;
    if (busy !== 1'b1 || imem.req !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_req_cycle busy %b req %b want 1 0", busy, imem.req);
    end
    step();
    n_run++;
    if (imem.req !== 1'b1 || imem.addr !== 30'h0C00) begin
      n_fail++;
      $display("FAIL basic_req req %b addr %h want 1 %h",
               imem.req, imem.addr, 30'h0C00);
    end
    step();
    n_run++;
    if (fetch_done !== 1'b1 || turn !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done done %b turn %b want 1 1", fetch_done, turn);
    end
    n_run++;
    if (instr !== 32'h2408_0005 || imminstr !== 26'h008_0005) begin
      n_fail++;
      $display("FAIL basic_ir instr %h imm %h want 24080005 0080005",
               instr, imminstr);
    end
    step();
    n_run++;
    if (fetch_done !== 1'b0 || turn !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_strobe done %b turn %b busy %b want 0 0 0",
               fetch_done, turn, busy);
    end
  endtask

  task automatic test_same_cycle_pcwr();
    int edges;
    logic [31:0] d;
    d = $urandom;
    mem_data = d;
    ack_delay = 0;
    pc_wr = 1'b1;
    npc = 30'h0C05;
    fetch_start = 1'b1;
    step();
    pc_wr = 1'b0;
    fetch_start = 1'b0;
    n_run++;
    if (pc !== 30'h0C05 || imem.addr !== 30'h0C05) begin
      n_fail++;
      $display("FAIL same_cycle pc %h addr %h want %h", pc, imem.addr, 30'h0C05);
    end
    edges = 1;
    while (!fetch_done && edges < 40) begin
      step();
      edges++;
    end
    n_run++;
    if (edges !== 3 || instr !== d) begin
      n_fail++;
      $display("FAIL same_cycle_done edges %0d instr %h want 3 %h", edges, instr, d);
    end
    step();
  endtask

  task automatic test_deferred_pcwr();
    int edges;
    int bad;
    pc_wr = 1'b1;
    npc = 30'h0C00;
    step();
    pc_wr = 1'b0;
    ack_delay = 5;
    mem_data = $urandom;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    edges = 1;
    bad = 0;
    while (!fetch_done && edges < 40) begin
      if (edges == 3) begin
        pc_wr = 1'b1;
        npc = 30'h0C10;
        fetch_start = 1'b1;
      end
      step();
      pc_wr = 1'b0;
      fetch_start = 1'b0;
      edges++;
      if (!fetch_done && (imem.req !== 1'b1 || imem.addr !== 30'h0C00)) bad++;
      if (pc !== 30'h0C00) bad++;
    end
    n_run++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL deferred_hold %0d bad cycles, want 0", bad);
    end
    n_run++;
    if (edges !== 8) begin
      n_fail++;
      $display("FAIL deferred_latency edges %0d want 8", edges);
    end
    step();
    n_run++;
    if (pc !== 30'h0C10 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL deferred_apply pc %h busy %b want %h 0", pc, busy, 30'h0C10);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    logic [31:0] d;
    ack_delay = 0;
    mem_data = $urandom;
    go(1'b0, 30'h0, edges);
    n_run++;
    if (edges !== 3 || fetch_done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first edges %0d done %b want 3 1", edges, fetch_done);
    end
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    n_run++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_during_done busy %b want 0", busy);
    end
    d = $urandom;
    mem_data = d;
    go(1'b0, 30'h0, edges);
    n_run++;
    if (edges !== 3 || instr !== d || imem.addr !== 30'h0C10) begin
      n_fail++;
      $display("FAIL b2b_second edges %0d instr %h addr %h want 3 %h %h",
               edges, instr, imem.addr, d, 30'h0C10);
    end
    step();
  endtask

  task automatic test_out_of_window();
    bit saw;
    pc_wr = 1'b1;
    npc = 30'h0400;
    step();
    pc_wr = 1'b0;
    ack_delay = 0;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    n_run++;
    if (fetch_err !== 1'b1 || busy !== 1'b0 || imem.req !== 1'b0) begin
      n_fail++;
      $display("FAIL oow_err err %b busy %b req %b want 1 0 0",
               fetch_err, busy, imem.req);
    end
    saw = 0;
    repeat (6) begin
      pc_wr = 1'b1;
      npc = 30'h0C00;
      fetch_start = 1'b1;
      step();
      if (imem.req !== 1'b0 || busy !== 1'b0) saw = 1;
    end
    pc_wr = 1'b0;
    fetch_start = 1'b0;
    n_run++;
    if (saw !== 1'b0 || pc !== 30'h0400 || fetch_err !== 1'b1) begin
      n_fail++;
      $display("FAIL oow_ignore req_seen %b pc %h err %b want 0 %h 1",
               saw, pc, fetch_err, 30'h0400);
    end
  endtask

  task automatic test_timeout();
    int edges;
    do_reset();
    ack_delay = -1;
    go(1'b0, 30'h0, edges);
    n_run++;
    if (fetch_err !== 1'b1 || edges !== 2 + TO || imem.req !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout err %b edges %0d req %b want 1 %0d 0",
               fetch_err, edges, imem.req, 2 + TO);
    end
    ack_force = 1'b1;
    force_data = 32'hDEAD_BEEF;
    step();
    step();
    ack_force = 1'b0;
    n_run++;
    if (instr !== 32'h0 || fetch_done !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_late_ack instr %h done %b want 0 0", instr, fetch_done);
    end
  endtask

  task automatic test_async_reset();
    int edges;
    do_reset();
    ack_delay = 0;
    mem_data = $urandom | 32'h1;
    go(1'b1, 30'h0C20, edges);
    step();
    ack_delay = -1;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    step();
    step();
    n_run++;
    if (imem.req !== 1'b1 || pc !== 30'h0C20) begin
      n_fail++;
      $display("FAIL arst_pre req %b pc %h want 1 %h", imem.req, pc, 30'h0C20);
    end
    #2;
    rst = 1'b0;
    #1;
    n_run++;
    if (pc !== 30'h0C00 || instr !== 32'h0 || imem.addr !== 30'h0) begin
      n_fail++;
      $display("FAIL arst_regs pc %h instr %h addr %h want %h 0 0",
               pc, instr, imem.addr, 30'h0C00);
    end
    n_run++;
    if ({imem.req, busy, turn, fetch_done, fetch_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL arst_flags got %b want 00000",
               {imem.req, busy, turn, fetch_done, fetch_err});
    end
    ack_force = 1'b1;
    force_data = 32'hCAFE_F00D;
    step();
    rst = 1'b1;
    step();
    ack_force = 1'b0;
    n_run++;
    if (instr !== 32'h0 || fetch_done !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_late_ack instr %h done %b want 0 0", instr, fetch_done);
    end
    ack_delay = 0;
    mem_data = 32'h2408_0005;
    go(1'b0, 30'h0, edges);
    n_run++;
    if (edges !== 3 || instr !== 32'h2408_0005 || imem.addr !== 30'h0C00) begin
      n_fail++;
      $display("FAIL arst_refetch edges %0d instr %h addr %h want 3 24080005 %h",
               edges, instr, imem.addr, 30'h0C00);
    end
    step();
  endtask

  task automatic test_random();
    logic [29:0] m_pc;
    logic [31:0] m_instr;
    bit          m_err;
    do_reset();
    m_pc = 30'h0C00;
    m_instr = '0;
    m_err = 0;
    for (int it = 0; it < 40; it++) begin
      bit use_wr, dwr, exp_req, saw_req;
      logic [29:0] nv, dnv, tgt;
      logic [31:0] data;
      int delay, exp_edges, edges, addr_bad;
      if (m_err) begin
        do_reset();
        m_pc = 30'h0C00;
        m_instr = '0;
        m_err = 0;
      end
      use_wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: nv = 30'h0BFF;
        1: nv = 30'h0C00;
        2: nv = 30'h0FFF;
        3: nv = 30'h1000;
        4: nv = 30'h0C00 + 30'($urandom_range(0, 1023));
        default: nv = 30'($urandom);
      endcase
      delay = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO, TO + 1))
                                           : int'($urandom_range(0, TO - 1));
      data = $urandom;
      dwr = 1'($urandom_range(0, 1));
      dnv = 30'h0C00 + 30'($urandom_range(0, 1023));
      tgt = use_wr ? nv : m_pc;
      if (use_wr) m_pc = nv;
      if (!model_inwin(tgt)) begin
        exp_edges = 1;
        m_err = 1;
        exp_req = 0;
      end else if (delay < TO) begin
        exp_edges = delay + 3;
        m_err = 0;
        exp_req = 1;
        m_instr = data;
      end else begin
        exp_edges = 2 + TO;
        m_err = 1;
        exp_req = 1;
      end
      ack_delay = delay;
      mem_data = data;
      pc_wr = use_wr;
      npc = nv;
      fetch_start = 1'b1;
      step();
      pc_wr = 1'b0;
      fetch_start = 1'b0;
      edges = 1;
      saw_req = 0;
      addr_bad = 0;
      while (!fetch_done && !fetch_err && edges < 40) begin
        if (edges == 2 && dwr) begin
          pc_wr = 1'b1;
          npc = dnv;
        end
        step();
        pc_wr = 1'b0;
        edges++;
        if (imem.req === 1'b1) begin
          saw_req = 1;
          if (imem.addr !== tgt) addr_bad++;
        end
      end
      n_run++;
      if (edges !== exp_edges || fetch_err !== m_err || saw_req !== exp_req) begin
        n_fail++;
        $display("FAIL rnd%0d_flow edges %0d err %b req %b want %0d %b %b",
                 it, edges, fetch_err, saw_req, exp_edges, m_err, exp_req);
      end
      n_run++;
      if (addr_bad !== 0 || instr !== m_instr) begin
        n_fail++;
        $display("FAIL rnd%0d_data addr_bad %0d instr %h want 0 %h",
                 it, addr_bad, instr, m_instr);
      end
      if (!m_err) begin
        step();
        if (dwr) m_pc = dnv;
      end
      n_run++;
      if (pc !== m_pc) begin
        n_fail++;
        $display("FAIL rnd%0d_pc got %h want %h", it, pc, m_pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_same_cycle_pcwr();
    test_deferred_pcwr();
    test_back_to_back();
    test_out_of_window();
    test_timeout();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
